// File: rtl/vga_timing_gen_pkg.sv
// Shared video timing constants: default 640x480@60 segment lengths and the
// line/frame total derivation, also used for window bounds by the text overlay.
package vga_timing_gen_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               hsync;
    logic               vsync;
    logic               active;
    logic               pix_stb;
    logic               newline;
    logic               newframe;
  } vga_out_t;

endpackage

// File: rtl/pix_strobe_div.sv
// Pixel-enable divider: tick is high for one clk every CLK_DIV clks while en,
// or every clk when CLK_DIV is 1. The count is parked at 0 while disabled.
module pix_strobe_div
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (!en || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with sync, active and pulse outputs,
// all registered from the same next-state so every output describes one (x,y).
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               pix_stb,
  output logic               newline,
  output logic               newframe
);

  localparam int H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (CLK_DIV < 1 || CLK_DIV > 4 || H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
      H_TOTAL < 1 || V_TOTAL < 1) begin : g_param_err
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic     tick;
  logic     x_wrap, y_wrap;
  logic [COORD_W-1:0] x_nx, y_nx;
  vga_out_t st, nx;

  pix_strobe_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // >= rather than == so a corrupted count still wraps back into range
  assign x_wrap = int'(st.x) >= H_TOTAL - 1;
  assign y_wrap = int'(st.y) >= V_TOTAL - 1;

  always_comb begin
    x_nx = st.x;
    y_nx = st.y;
    if (!en) begin
      x_nx = '0;
      y_nx = '0;
    end else if (tick) begin
      x_nx = x_wrap ? '0 : st.x + 1'b1;
      if (x_wrap) y_nx = y_wrap ? '0 : st.y + 1'b1;
    end
  end

  // Outputs decode the next position so they land in the same cycle as x/y
  always_comb begin
    nx          = '0;
    nx.x        = x_nx;
    nx.y        = y_nx;
    nx.hsync    = (en && int'(x_nx) >= HS_START && int'(x_nx) < HS_END) ? HS_POL : !HS_POL;
    nx.vsync    = (en && int'(y_nx) >= VS_START && int'(y_nx) < VS_END) ? VS_POL : !VS_POL;
    nx.active   = en && int'(x_nx) < H_ACTIVE && int'(y_nx) < V_ACTIVE;
    nx.pix_stb  = tick;
    nx.newline  = tick && x_wrap;
    nx.newframe = tick && x_wrap && y_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= '0;
      st.hsync <= !HS_POL;
      st.vsync <= !VS_POL;
    end else begin
      st <= nx;
    end
  end

  assign x        = st.x;
  assign y        = st.y;
  assign hsync    = st.hsync;
  assign vsync    = st.vsync;
  assign active   = st.active;
  assign pix_stb  = st.pix_stb;
  assign newline  = st.newline;
  assign newframe = st.newframe;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a CLK_DIV=1 / HS_POL=1 instance
// with a short 8-line frame so frame-level timing fits in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en1 = 1'b0;
  logic en2 = 1'b0;

  logic [9:0] x1, y1, x2, y2;
  logic hs1, vs1, act1, stb1, nl1, nf1;
  logic hs2, vs2, act2, stb2, nl2, nf2;

  int errors = 0;
  int checks = 0;

  logic en1_q = 1'b0;
  logic en2_q = 1'b0;

  int nl1_per = 0, hs1_runs = 0;
  int nl2_per = 0, hs2_runs = 0, nf2_cnt = 0, nf2_per = 0, vs2_runs = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .x(x1), .y(y1), .hsync(hs1), .vsync(vs1),
    .active(act1), .pix_stb(stb1), .newline(nl1), .newframe(nf1)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .HS_POL(1'b1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .x(x2), .y(y2), .hsync(hs2), .vsync(vs2),
    .active(act2), .pix_stb(stb2), .newline(nl2), .newframe(nf2)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Tracks whether each DUT saw en=1 at the last edge, so monitors skip idle cycles
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      en1_q = 1'b0;
      en2_q = 1'b0;
    end else begin
      en1_q = en1;
      en2_q = en2;
    end
  end

  // Every-cycle alignment and periodic timing monitor
  initial begin
    int ncyc, nl1_last, hs1_run, nl2_last, hs2_run, nf2_last, vs2_run;
    ncyc = 0; nl1_last = -1; hs1_run = 0;
    nl2_last = -1; hs2_run = 0; nf2_last = -1; vs2_run = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst && en1_q) begin
        chk("align1", {act1, hs1, vs1},
            {(x1 < 640 && y1 < 480), !(x1 >= 656 && x1 <= 751), !(y1 >= 490 && y1 <= 491)});
        chk("range1", (x1 < 800 && y1 < 525), 1);
        if (nl1) begin
          chk("nl1_x", x1, 0);
          if (nl1_last >= 0) begin chk("nl1_period", ncyc - nl1_last, 1600); nl1_per++; end
          nl1_last = ncyc;
        end
        if (!hs1) hs1_run++;
        else begin
          if (hs1_run != 0) begin chk("hs1_width", hs1_run, 192); hs1_runs++; end
          hs1_run = 0;
        end
      end else begin
        nl1_last = -1; hs1_run = 0;
      end

      if (!rst && en2_q) begin
        chk("align2", {act2, hs2, vs2},
            {(x2 < 640 && y2 < 4), (x2 >= 656 && x2 <= 751), !(y2 >= 5 && y2 <= 6)});
        chk("range2", (x2 < 800 && y2 < 8), 1);
        chk("stb2_const", stb2, 1);
        if (nl2) begin
          if (nl2_last >= 0) begin chk("nl2_period", ncyc - nl2_last, 800); nl2_per++; end
          nl2_last = ncyc;
        end
        if (nf2) begin
          chk("nf2_with_nl", {nl2, x2, y2}, {1'b1, 10'd0, 10'd0});
          if (nf2_last >= 0) begin chk("nf2_period", ncyc - nf2_last, 6400); nf2_per++; end
          nf2_last = ncyc;
          nf2_cnt++;
        end
        if (hs2) hs2_run++;
        else begin
          if (hs2_run != 0) begin chk("hs2_width", hs2_run, 96); hs2_runs++; end
          hs2_run = 0;
        end
        if (!vs2) vs2_run++;
        else begin
          if (vs2_run != 0) begin chk("vs2_width", vs2_run, 1600); vs2_runs++; end
          vs2_run = 0;
        end
      end else begin
        nl2_last = -1; hs2_run = 0; nf2_last = -1; vs2_run = 0;
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_pos1",   {x1, y1}, 0);
    chk("rst_sync1",  {hs1, vs1}, 2'b11);
    chk("rst_pulse1", {act1, stb1, nl1, nf1}, 0);
    chk("rst_pos2",   {x2, y2}, 0);
    chk("rst_sync2",  {hs2, vs2}, 2'b01);
    chk("rst_pulse2", {act2, stb2, nl2, nf2}, 0);

    rst = 1'b0; en1 = 1'b1; en2 = 1'b1;
    @(negedge clk);
    chk("start_x1",     x1, 0);
    chk("start_pulse1", {stb1, nl1, nf1}, 0);
    chk("start_stb2",   {stb2, x2, nl2}, {1'b1, 10'd1, 1'b0});
    @(negedge clk);
    chk("first_stb1",   {stb1, x1}, {1'b1, 10'd1});

    n = 0;
    while (!(x1 == 300 && y1 == 2) && n < 10000) begin @(negedge clk); n++; end
    chk("reach_300_2", (x1 == 300 && y1 == 2), 1);
    chk("mid_active1", act1, 1);

    en1 = 1'b0;
    @(negedge clk);
    chk("dis_pos1",   {x1, y1}, 0);
    chk("dis_sync1",  {hs1, vs1}, 2'b11);
    chk("dis_pulse1", {act1, stb1, nl1, nf1}, 0);
    repeat (5) @(negedge clk);
    chk("hold_pos1",   {x1, y1}, 0);
    chk("hold_pulse1", {act1, stb1, nl1, nf1, hs1, vs1}, 6'b000011);

    en1 = 1'b1;
    @(negedge clk);
    chk("re_x1",     {x1, y1}, 0);
    chk("re_pulse1", {stb1, nl1, nf1}, 0);
    @(negedge clk);
    chk("re_stb1",   {stb1, x1}, {1'b1, 10'd1});

    n = 0;
    while (!nl1 && n < 2000) begin @(negedge clk); n++; end
    chk("re_nl1_seen", nl1, 1);
    chk("re_nl1_y",    {y1, nf1}, {10'd1, 1'b0});

    n = 0;
    while (nf2_cnt < 3 && n < 30000) begin @(negedge clk); n++; end
    chk("nf2_seen", nf2_cnt >= 3, 1);

    rst = 1'b1;
    #1;
    chk("mrst_pos1",   {x1, y1}, 0);
    chk("mrst_sync1",  {hs1, vs1}, 2'b11);
    chk("mrst_pulse1", {act1, stb1, nl1, nf1}, 0);
    chk("mrst_pos2",   {x2, y2}, 0);
    chk("mrst_sync2",  {hs2, vs2}, 2'b01);
    chk("mrst_pulse2", {act2, stb2, nl2, nf2}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_x1",     {x1, y1}, 0);
    chk("rel_pulse1", {stb1, nl1, nf1}, 0);
    @(negedge clk);
    chk("rel_stb1",   {stb1, x1, nl1}, {1'b1, 10'd1, 1'b0});

    chk("nl1_periods_seen", nl1_per >= 2, 1);
    chk("hs1_runs_seen",    hs1_runs >= 2, 1);
    chk("nl2_periods_seen", nl2_per >= 2, 1);
    chk("hs2_runs_seen",    hs2_runs >= 2, 1);
    chk("nf2_periods_seen", nf2_per >= 2, 1);
    chk("vs2_runs_seen",    vs2_runs >= 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
